ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-003 SHALL have inputs valid_i (1), stall_i (1), flush_i (1): EX instruction valid, MEM-side hold, kill EX instruction.
REQ-004 SHALL have inputs alu_result_i (32), Z_i, N_i, S_i, C_i, V_i (1 each): ALU result and flags.
REQ-005 SHALL have inputs ctrl_branch_i (1), ctrl_jump_i (1), branch_funct3_i (3): conditional branch, JAL/JALR, branch condition code.
REQ-006 SHALL have inputs pc_i (32), branch_target_i (32), store_data_i (32), rd_addr_i (5), reg_write_i, mem_read_i, mem_write_i (1 each).
REQ-007 SHALL have outputs valid_o, reg_write_o, mem_read_o, mem_write_o (1 each), result_o (32), store_data_o (32), rd_addr_o (5): registered MEM-stage payload.
REQ-008 SHALL have outputs redirect_o (1), redirect_pc_o (32), misaligned_o (1): registered control-flow redirect and target-misalignment trap.
REQ-009 SHALL have outputs branch_count_o (32), taken_count_o (32): performance counters.

Function
REQ-010 "Capture" SHALL mean a rising edge with stall_i=0 and flush_i=0; every payload register then loads from its input.
REQ-011 Condition "taken" SHALL be ctrl_jump_i, or ctrl_branch_i with funct3: 000 Z_i; 001 !Z_i; 100 S_i; 101 !S_i; 110 C_i; 111 !C_i; 010/011 never taken.
REQ-012 C_i SHALL be interpreted as the ALU SUB borrow (1 when a < b unsigned); V_i and N_i SHALL be used only via S_i.
REQ-013 On capture, result_o SHALL load pc_i + 4 (mod 2^32) when ctrl_jump_i=1, otherwise alu_result_i.
REQ-014 On capture with valid_i=1 and taken, redirect_o SHALL be 1 and redirect_pc_o SHALL be branch_target_i with bit 0 cleared; otherwise redirect_o SHALL be 0 and redirect_pc_o SHALL hold its value.
REQ-015 On capture with valid_i=1, taken and branch_target_i[1]=1, misaligned_o SHALL be 1 and reg_write_o, mem_read_o, mem_write_o SHALL load 0; otherwise misaligned_o SHALL be 0.
REQ-016 On capture with valid_i=0, valid_o, reg_write_o, mem_read_o, mem_write_o, redirect_o, misaligned_o SHALL load 0 (bubble).
REQ-017 When flush_i=1, the next edge SHALL load a bubble regardless of stall_i (flush has priority over stall).
REQ-018 When stall_i=1 and flush_i=0, all outputs except redirect_o and misaligned_o SHALL hold; redirect_o and misaligned_o SHALL clear to 0, so each event pulses exactly one cycle.
REQ-019 Latency SHALL be one cycle: inputs at capture edge N appear on outputs after edge N.
REQ-020 branch_count_o SHALL increment on capture with valid_i=1 and ctrl_branch_i=1; taken_count_o SHALL additionally require taken; jumps SHALL count in neither.
REQ-021 Counters SHALL wrap from 0xFFFFFFFF to 0; they SHALL not change on stall, flush or bubble.

Reset
REQ-022 While reset_i=1, all outputs and counters SHALL be 0 immediately, independent of clk_i.
REQ-023 Reset asserted mid-stall or mid-redirect SHALL discard the held instruction; first capture after deassertion SHALL behave per REQ-010..021.

Verification
REQ-024 BEQ, funct3=000, Z_i=1, target 0x00000100, valid_i=1 -> next cycle redirect_o=1, redirect_pc_o=0x00000100, taken_count_o=1, branch_count_o=1; redirect_o=0 the cycle after.
REQ-025 BLTU, funct3=110, C_i=0 -> redirect_o=0, branch_count_o=1, taken_count_o=0; same with C_i=1 -> redirect_o=1.
REQ-026 JAL, pc_i=0x00000FFC, target 0x00002001, rd_addr_i=1 -> result_o=0x00001000, redirect_pc_o=0x00002000, counters unchanged.
REQ-027 Taken branch captured then stall_i=1 for 3 cycles -> redirect_o high exactly 1 cycle, payload held 3 cycles; flush_i=1 with stall_i=1 -> valid_o=0 next cycle.
REQ-028 Taken jump, target 0x00000102 -> misaligned_o=1, reg_write_o=0 for one cycle; taken_count_o preset to 0xFFFFFFFF plus a taken branch -> 0x00000000; reset_i pulse mid-cycle -> all outputs 0 before next edge.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, one-cycle redirect pulse,
// target-misalignment trap and branch/taken performance counters.
module ex_mem_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] alu_result_i,
  input  logic        Z_i,
  input  logic        N_i,
  input  logic        S_i,
  input  logic        C_i,
  input  logic        V_i,
  input  logic        ctrl_branch_i,
  input  logic        ctrl_jump_i,
  input  logic [2:0]  branch_funct3_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  output logic        valid_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] result_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        misaligned_o,
  output logic [31:0] branch_count_o,
  output logic [31:0] taken_count_o
);

  logic        taken;
  logic        misalign;
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;
  logic        unused_flags;

  // N and V only matter through S, which the ALU already folds together
  assign unused_flags = &{1'b0, N_i, V_i};

  always_comb begin
    taken = 1'b0;
    if (ctrl_jump_i) begin
      taken = 1'b1;
    end else if (ctrl_branch_i) begin
      case (branch_funct3_i)
        3'b000:  taken = Z_i;
        3'b001:  taken = ~Z_i;
        3'b100:  taken = S_i;
        3'b101:  taken = ~S_i;
        3'b110:  taken = C_i;
        3'b111:  taken = ~C_i;
        default: taken = 1'b0;
      endcase
    end
  end

  assign misalign = taken & branch_target_i[1];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o       <= 1'b0;
      reg_write_o   <= 1'b0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      result_o      <= '0;
      store_data_o  <= '0;
      rd_addr_o     <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      misaligned_o  <= 1'b0;
      branch_cnt    <= '0;
      taken_cnt     <= '0;
    end else if (flush_i) begin
      valid_o      <= 1'b0;
      reg_write_o  <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      redirect_o   <= 1'b0;
      misaligned_o <= 1'b0;
    end else if (stall_i) begin
      // payload holds; event outputs drop so each redirect/trap is a single pulse
      redirect_o   <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      valid_o      <= valid_i;
      result_o     <= ctrl_jump_i ? (pc_i + 32'd4) : alu_result_i;
      store_data_o <= store_data_i;
      rd_addr_o    <= rd_addr_i;
      if (valid_i) begin
        reg_write_o  <= reg_write_i & ~misalign;
        mem_read_o   <= mem_read_i & ~misalign;
        mem_write_o  <= mem_write_i & ~misalign;
        redirect_o   <= taken;
        misaligned_o <= misalign;
        if (taken) redirect_pc_o <= {branch_target_i[31:1], 1'b0};
        if (ctrl_branch_i) branch_cnt <= branch_cnt + 32'd1;
        if (ctrl_branch_i && taken) taken_cnt <= taken_cnt + 32'd1;
      end else begin
        reg_write_o  <= 1'b0;
        mem_read_o   <= 1'b0;
        mem_write_o  <= 1'b0;
        redirect_o   <= 1'b0;
        misaligned_o <= 1'b0;
      end
    end
  end

  assign branch_count_o = branch_cnt;
  assign taken_count_o  = taken_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed + randomized bench for ex_mem_stage; expectations come from an
// operand-level branch model (a/b comparisons), not from ALU flag decoding.
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i, stall_i, flush_i;
  logic [31:0] alu_result_i;
  logic        Z_i, N_i, S_i, C_i, V_i;
  logic        ctrl_branch_i, ctrl_jump_i;
  logic [2:0]  branch_funct3_i;
  logic [31:0] pc_i, branch_target_i, store_data_i;
  logic [4:0]  rd_addr_i;
  logic        reg_write_i, mem_read_i, mem_write_i;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o;
  logic [31:0] result_o, store_data_o;
  logic [4:0]  rd_addr_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        misaligned_o;
  logic [31:0] branch_count_o, taken_count_o;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] op_a, op_b;
  logic        m_valid, m_rw, m_mr, m_mw, m_redir, m_mis;
  logic [31:0] m_res, m_sd, m_rpc, m_bc, m_tc;
  logic [4:0]  m_rd;

  ex_mem_stage dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .alu_result_i(alu_result_i), .Z_i(Z_i), .N_i(N_i),
    .S_i(S_i), .C_i(C_i), .V_i(V_i), .ctrl_branch_i(ctrl_branch_i),
    .ctrl_jump_i(ctrl_jump_i), .branch_funct3_i(branch_funct3_i), .pc_i(pc_i),
    .branch_target_i(branch_target_i), .store_data_i(store_data_i),
    .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .valid_o(valid_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .result_o(result_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .misaligned_o(misaligned_o),
    .branch_count_o(branch_count_o), .taken_count_o(taken_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ALU computes a-b; flags derived exactly as a subtracting ALU would
  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    op_a = a; op_b = b; d = a - b;
    alu_result_i = d;
    Z_i = (a == b);
    C_i = (a < b);
    N_i = d[31];
    V_i = (a[31] != b[31]) && (d[31] != a[31]);
    S_i = N_i ^ V_i;
  endtask

  function automatic logic branch_taken();
    if (ctrl_jump_i) return 1'b1;
    if (!ctrl_branch_i) return 1'b0;
    case (branch_funct3_i)
      3'd0: return op_a == op_b;
      3'd1: return op_a != op_b;
      3'd4: return $signed(op_a) < $signed(op_b);
      3'd5: return $signed(op_a) >= $signed(op_b);
      3'd6: return op_a < op_b;
      3'd7: return op_a >= op_b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw, m_redir, m_mis} = '0;
    m_res = '0; m_sd = '0; m_rpc = '0; m_bc = '0; m_tc = '0; m_rd = '0;
  endtask

  task automatic model_edge();
    logic tk, mis;
    tk = branch_taken();
    mis = tk && branch_target_i[1];
    if (flush_i) begin
      {m_valid, m_rw, m_mr, m_mw, m_redir, m_mis} = '0;
    end else if (stall_i) begin
      m_redir = 1'b0; m_mis = 1'b0;
    end else begin
      m_valid = valid_i;
      m_res = ctrl_jump_i ? pc_i + 32'd4 : alu_result_i;
      m_sd = store_data_i;
      m_rd = rd_addr_i;
      if (valid_i) begin
        m_rw = reg_write_i && !mis;
        m_mr = mem_read_i && !mis;
        m_mw = mem_write_i && !mis;
        m_redir = tk;
        m_mis = mis;
        if (tk) m_rpc = branch_target_i & ~32'd1;
        if (ctrl_branch_i) begin
          m_bc = m_bc + 1;
          if (tk) m_tc = m_tc + 1;
        end
      end else begin
        {m_rw, m_mr, m_mw, m_redir, m_mis} = '0;
      end
    end
  endtask

  task automatic check_all();
    chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
    chk("reg_write", {31'd0, reg_write_o}, {31'd0, m_rw});
    chk("mem_read", {31'd0, mem_read_o}, {31'd0, m_mr});
    chk("mem_write", {31'd0, mem_write_o}, {31'd0, m_mw});
    chk("result", result_o, m_res);
    chk("store_data", store_data_o, m_sd);
    chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, m_rd});
    chk("redirect", {31'd0, redirect_o}, {31'd0, m_redir});
    chk("redirect_pc", redirect_pc_o, m_rpc);
    chk("misaligned", {31'd0, misaligned_o}, {31'd0, m_mis});
    chk("branch_count", branch_count_o, m_bc);
    chk("taken_count", taken_count_o, m_tc);
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    ctrl_branch_i = 1'b0; ctrl_jump_i = 1'b0; branch_funct3_i = 3'd0;
    pc_i = '0; branch_target_i = '0; store_data_i = '0; rd_addr_i = '0;
    reg_write_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    set_ops(32'd1, 32'd2);
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] tgt);
    idle();
    valid_i = 1'b1; ctrl_branch_i = 1'b1; branch_funct3_i = f3;
    branch_target_i = tgt; pc_i = 32'h0000_0040;
    set_ops(a, b);
  endtask

  initial begin
    int hi_cnt;
    idle();
    reset_i = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk_i); #1;
    check_all();
    reset_i = 1'b0;

    // BEQ taken to 0x100
    branch(3'd0, 32'd7, 32'd7, 32'h0000_0100);
    step();
    chk("beq_redirect", {31'd0, redirect_o}, 32'd1);
    chk("beq_pc", redirect_pc_o, 32'h0000_0100);
    chk("beq_taken_cnt", taken_count_o, 32'd1);
    chk("beq_branch_cnt", branch_count_o, 32'd1);
    idle();
    step();
    chk("beq_pulse_end", {31'd0, redirect_o}, 32'd0);

    // BLTU not taken (a >= b), then taken (a < b)
    branch(3'd6, 32'd9, 32'd3, 32'h0000_0200);
    step();
    chk("bltu_nt_redirect", {31'd0, redirect_o}, 32'd0);
    branch(3'd6, 32'd3, 32'hFFFF_0000, 32'h0000_0200);
    step();
    chk("bltu_t_redirect", {31'd0, redirect_o}, 32'd1);

    // JAL with bit-0 set target
    idle();
    valid_i = 1'b1; ctrl_jump_i = 1'b1; pc_i = 32'h0000_0FFC;
    branch_target_i = 32'h0000_2001; rd_addr_i = 5'd1; reg_write_i = 1'b1;
    step();
    chk("jal_result", result_o, 32'h0000_1000);
    chk("jal_pc", redirect_pc_o, 32'h0000_2000);
    chk("jal_branch_cnt", branch_count_o, 32'd3);

    // taken branch then 3-cycle stall, then flush under stall
    branch(3'd1, 32'd1, 32'd2, 32'h0000_0300);
    store_data_i = 32'hA5A5_1234; rd_addr_i = 5'd9; reg_write_i = 1'b1;
    step();
    hi_cnt = int'(redirect_o);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      store_data_i = $urandom; rd_addr_i = 5'($urandom);
      step();
      hi_cnt += int'(redirect_o);
      chk("stall_hold_sd", store_data_o, 32'hA5A5_1234);
    end
    chk("stall_redirect_pulses", hi_cnt, 32'd1);
    flush_i = 1'b1;
    step();
    chk("flush_valid", {31'd0, valid_o}, 32'd0);

    // misaligned jump target
    idle();
    valid_i = 1'b1; ctrl_jump_i = 1'b1; pc_i = 32'h0000_0010;
    branch_target_i = 32'h0000_0102; reg_write_i = 1'b1; rd_addr_i = 5'd2;
    step();
    chk("mis_flag", {31'd0, misaligned_o}, 32'd1);
    chk("mis_reg_write", {31'd0, reg_write_o}, 32'd0);
    idle();
    step();
    chk("mis_pulse_end", {31'd0, misaligned_o}, 32'd0);

    // taken counter wrap
    @(negedge clk_i);
    force dut.taken_cnt = 32'hFFFF_FFFF;
    #1 release dut.taken_cnt;
    m_tc = 32'hFFFF_FFFF;
    branch(3'd0, 32'd5, 32'd5, 32'h0000_0400);
    step();
    chk("taken_wrap", taken_count_o, 32'd0);

    // randomized traffic with occasional async reset pulses
    for (int n = 0; n < 600; n++) begin
      int kind;
      idle();
      kind = int'($urandom_range(0, 9));
      valid_i = ($urandom_range(0, 7) != 0);
      stall_i = ($urandom_range(0, 5) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      ctrl_branch_i = (kind < 4);
      ctrl_jump_i = (kind == 4);
      branch_funct3_i = 3'($urandom);
      pc_i = $urandom;
      branch_target_i = $urandom;
      store_data_i = $urandom;
      rd_addr_i = 5'($urandom);
      reg_write_i = 1'($urandom);
      mem_read_i = 1'($urandom);
      mem_write_i = 1'($urandom);
      op_b = $urandom;
      op_a = ($urandom_range(0, 3) == 0) ? op_b : $urandom;
      set_ops(op_a, op_b);
      step();
      if (n % 97 == 50) begin
        #2 reset_i = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk_i); #1;
        check_all();
        reset_i = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
